muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer with its HI/LO result registers. Accepts

---
 rtl/muldiv_seq_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_muldiv_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states and
// the single-step mode select.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step
// on a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  step_mode_e             mode,
  input  logic [2*WIDTH-1:0]     acc,
  input  logic [WIDTH-1:0]       operand,
  output logic [2*WIDTH-1:0]     acc_next,
  output logic [WIDTH-1:0]       part_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_upper;
  logic             div_qbit;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, upper half the partial sum.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: remainder shifted left with the next dividend bit brought in.
    div_rem   = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_rem - {1'b0, operand};
    div_qbit  = ~div_diff[WIDTH];
    div_upper = div_qbit ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];

    if (mode == STEP_DIV) begin
      acc_next = {div_upper, acc[WIDTH-2:0], div_qbit};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
    part_next = acc_next[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer with HI/LO registers; also services
// MTHI/MTLO and holds the pipeline via busy while a multi-cycle op runs.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  md_state_e          state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   part_q;
  step_mode_e         mode_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_part;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode     (mode_q),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (step_acc),
    .part_next(step_part)
  );

  always_comb begin
    op_signed = md_is_signed(op);
    a_neg     = op_signed & op_a[WIDTH-1];
    b_neg     = op_signed & op_b[WIDTH-1];
    a_mag     = a_neg ? -op_a : op_a;
    b_mag     = b_neg ? -op_b : op_b;
    // Sign correction applied on the way into HI/LO.
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -part_q : part_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      part_q    <= '0;
      mode_q    <= STEP_MUL;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (!pause) begin
      case (state_q)
        MD_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                acc_q     <= {{WIDTH{1'b0}}, b_mag};
                opnd_q    <= a_mag;
                mode_q    <= STEP_MUL;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= 1'b0;
                cnt_q     <= '0;
                busy_q    <= 1'b1;
                state_q   <= MD_CALC;
              end
              MD_DIV, MD_DIVU: begin
                busy_q <= 1'b1;
                if (op_b == '0) begin
                  // Divide by zero: no iteration, fixed result straight into HI/LO.
                  hi_q    <= op_a;
                  lo_q    <= '1;
                  done_q  <= 1'b1;
                  state_q <= MD_DONE;
                end else begin
                  acc_q     <= {{WIDTH{1'b0}}, a_mag};
                  opnd_q    <= b_mag;
                  mode_q    <= STEP_DIV;
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  cnt_q     <= '0;
                  state_q   <= MD_CALC;
                end
              end
              MD_MTHI: hi_q <= op_a;
              MD_MTLO: lo_q <= op_a;
              default: ;
            endcase
          end
        end
        MD_CALC: begin
          acc_q  <= step_acc;
          part_q <= step_part;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            state_q <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (mode_q == STEP_DIV) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= MD_DONE;
        end
        MD_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: issued ops push expected {hi,lo}; a monitor
// pops and compares on every done pulse.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         pause;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic        done_prev = 1'b0;

  always #5 clk = ~clk;

  muldiv_seq #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pause(pause),
    .start(start),
    .op   (op),
    .op_a (op_a),
    .op_b (op_b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: one pop per rising edge of done.
  always @(negedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%h%h required=none", hi, lo);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", {hi, lo}, mon_exp);
        end
      end
      done_prev <= done;
    end
  end

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_cycles,
                        input int pause_at, input int pause_len, input int restart_at);
    logic [63:0] old;
    int          k;
    int          busy_n;
    int          done_k;
    bit          hold_ok;
    @(negedge clk);
    old = {hi, lo};
    exp_q.push_back(exp);
    op    = o;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = MD_NOP;
    k       = 0;
    busy_n  = 0;
    done_k  = -1;
    hold_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (busy) busy_n++;
      if (done && done_k < 0) done_k = k;
      if (busy && !done && ({hi, lo} !== old)) hold_ok = 1'b0;
      if (k == pause_at) pause = 1'b1;
      if (k == pause_at + pause_len) pause = 1'b0;
      if (k == restart_at) begin
        start = 1'b1;
        op    = MD_MULTU;
        op_a  = 32'd9;
        op_b  = 32'd9;
      end
      if (k == restart_at + 1) begin
        start = 1'b0;
        op    = MD_NOP;
      end
    end while ((busy || pause) && k < 200);
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=<200", name, k);
    end
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_cycles));
    check({name, "_done_cycle"}, 64'(done_k), 64'(exp_cycles));
    check({name, "_hold"}, 64'(hold_ok), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    pause = 1'b0;
    start = 1'b0;
    op    = MD_NOP;
    op_a  = '0;
    op_b  = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, 34, 0, 0, 0);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0, 0, 0);
    run_op("mult_m3_5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 34, 0, 0, 0);
    run_op("mult_m2_m3", MD_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd6, 34, 0, 0, 0);
    run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 34, 0, 0, 0);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 34, 0, 0, 0);
    run_op("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000,
           34, 0, 0, 0);
    run_op("divu_by0", MD_DIVU, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1, 0, 0, 0);

    run_op("mult_pause", MD_MULT, 32'd6, 32'd7, 64'd42, 39, 10, 5, 20);
    repeat (40) @(negedge clk);
    check("ignored_start_hilo", {hi, lo}, 64'd42);
    check("ignored_start_busy", 64'(busy), 64'd0);

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    start = 1'b1;
    op    = MD_MTHI;
    op_a  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("mthi_hilo", {hi, lo}, 64'hDEAD_BEEF_0000_002A);
    check("mthi_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    op   = MD_MTLO;
    op_a = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MD_NOP;
    check("mtlo_hilo", {hi, lo}, 64'hDEAD_BEEF_0BAD_F00D);
    check("mtlo_busy_done", {62'd0, busy, done}, 64'd0);

    // Unknown op code acts as a NOP.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd7;
    op_a  = 32'h1111_1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MD_NOP;
    @(negedge clk);
    check("unknown_op_hilo", {hi, lo}, 64'hDEAD_BEEF_0BAD_F00D);
    check("unknown_op_busy", 64'(busy), 64'd0);

    // Reset in the middle of CALC aborts and clears HI/LO.
    @(negedge clk);
    start = 1'b1;
    op    = MD_MULTU;
    op_a  = 32'd100;
    op_b  = 32'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MD_NOP;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("multu_after_rst", MD_MULTU, 32'd2, 32'd3, 64'd6, 34, 0, 0, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
